// File: rtl/pong_pkg.sv
// Shared constants and types for the Pong datapath blocks.
// Field geometry, referee defaults and the score arithmetic live here.
package pong_pkg;

  localparam int SCREEN_W    = 1024;
  localparam int XPOS_W      = 11;
  localparam int SCORE_W     = 7;
  localparam int SCORE_MAX   = 99;

  localparam int X_LEFT      = 0;
  localparam int X_RIGHT     = SCREEN_W;
  localparam int WIN_POINTS  = 11;
  localparam int HOLD_CYCLES = 65_000_000;

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} score_state_t;
  typedef enum logic {PLAYER_1, PLAYER_2} player_t;

  // Saturating score increment; the display cannot show more than two digits.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    logic [SCORE_W-1:0] r;
    r = s;
    if (s < SCORE_W'(SCORE_MAX)) r = s + SCORE_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Fixed-length interval timer: start launches a CYCLES-long busy window,
// done flags its final cycle. Counts up or down depending on COUNT_DOWN.
module hold_timer #(
  parameter int CYCLES     = 8,
  parameter bit COUNT_DOWN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic busy,
  output logic done
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] FIRST = COUNT_DOWN ? CNT_END : CNT_ZERO;
  localparam logic [CNT_W-1:0] LAST  = COUNT_DOWN ? CNT_ZERO : CNT_END;

  logic [CNT_W-1:0] cnt_q;

  assign done = busy && (cnt_q == LAST);

  // clear outranks start so an abort in the same cycle as a launch wins
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      busy  <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt_q <= FIRST;
    end else if (busy) begin
      if (cnt_q == LAST) begin
        busy <= 1'b0;
      end else if (COUNT_DOWN) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_ctl.sv
// Pong referee: detects misses at the field edges, keeps both scores,
// runs the serve delay and declares the winner.
//
//   state | meaning
//   IDLE  | after reset; scores frozen, hits ignored until new_game
//   PLAY  | ball live; an edge hit credits a point
//   HOLD  | serve delay running; ball parked at centre, hits ignored
//   OVER  | winning score reached; everything held until new_game
module score_ctl
  import pong_pkg::*;
#(
  parameter int X_LEFT      = pong_pkg::X_LEFT,
  parameter int X_RIGHT     = pong_pkg::X_RIGHT,
  parameter int WIN_POINTS  = pong_pkg::WIN_POINTS,
  parameter int HOLD_CYCLES = pong_pkg::HOLD_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XPOS_W-1:0]  xpos,
  input  logic               new_game,
  output logic [SCORE_W-1:0] points_first_player,
  output logic [SCORE_W-1:0] points_second_player,
  output logic               point_scored,
  output logic               scorer,
  output logic               serve_hold,
  output logic               game_over,
  output logic               winner
);

  if (WIN_POINTS < 1 || WIN_POINTS > SCORE_MAX || HOLD_CYCLES < 2) begin : g_param_err
    $error("score_ctl: WIN_POINTS must be 1..99 and HOLD_CYCLES at least 2");
  end

  localparam logic [XPOS_W-1:0]  X_L = XPOS_W'(X_LEFT);
  localparam logic [XPOS_W-1:0]  X_R = XPOS_W'(X_RIGHT);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_POINTS);

  score_state_t       state_q, state_d;
  logic [XPOS_W-1:0]  xpos_prev;
  logic [SCORE_W-1:0] p1_q, p2_q;
  player_t            scorer_q, winner_q;
  logic               pulse_q;

  logic               left_hit, right_hit;
  logic               hit_take;
  player_t            credit;
  logic [SCORE_W-1:0] p1_inc, p2_inc;
  logic               win_hit;
  logic               timer_start, timer_done, timer_busy;

  assign left_hit  = (xpos == X_L) && (xpos_prev != X_L);
  assign right_hit = (xpos >= X_R) && (xpos_prev < X_R);

  assign p1_inc = score_inc(p1_q);
  assign p2_inc = score_inc(p2_q);

  always_comb begin
    credit      = left_hit ? PLAYER_2 : PLAYER_1;
    hit_take    = (state_q == PLAY) && (left_hit || right_hit) && !new_game;
    win_hit     = (credit == PLAYER_2) ? (p2_inc == WIN) : (p1_inc == WIN);
    timer_start = hit_take && !win_hit;
    state_d     = state_q;
    unique case (state_q)
      IDLE: if (new_game) state_d = PLAY;
      PLAY: begin
        if (new_game)     state_d = PLAY;
        else if (hit_take) state_d = win_hit ? OVER : HOLD;
      end
      HOLD: if (new_game || timer_done) state_d = PLAY;
      OVER: if (new_game) state_d = PLAY;
      default: state_d = IDLE;
    endcase
  end

  hold_timer #(
    .CYCLES     (HOLD_CYCLES),
    .COUNT_DOWN (1'b0)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start),
    .clear (new_game),
    .busy  (timer_busy),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    xpos_prev <= xpos;
    if (rst) begin
      state_q  <= IDLE;
      p1_q     <= '0;
      p2_q     <= '0;
      scorer_q <= PLAYER_1;
      winner_q <= PLAYER_1;
      pulse_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= hit_take;
      if (new_game) begin
        p1_q     <= '0;
        p2_q     <= '0;
        winner_q <= PLAYER_1;
      end else if (hit_take) begin
        scorer_q <= credit;
        if (credit == PLAYER_2) p2_q <= p2_inc;
        else                    p1_q <= p1_inc;
        if (win_hit) winner_q <= credit;
      end
    end
  end

  assign points_first_player  = p1_q;
  assign points_second_player = p2_q;
  assign point_scored         = pulse_q;
  assign scorer               = scorer_q;
  assign winner               = winner_q;
  // HOLD tracks the timer window exactly; busy is kept for the shared timer interface
  assign serve_hold           = (state_q == HOLD) && timer_busy;
  assign game_over            = (state_q == OVER);

endmodule

// File: tb/tb_score_ctl.sv
// Self-checking bench for score_ctl with WIN_POINTS=3, HOLD_CYCLES=8,
// comparing against a game-level referee model kept in the bench.
module tb_score_ctl;

  localparam int WIN  = 3;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_game;
  logic [10:0] xpos;
  logic [6:0]  p1, p2;
  logic        point_scored, scorer, serve_hold, game_over, winner;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_ctl #(
    .X_LEFT      (0),
    .X_RIGHT     (1024),
    .WIN_POINTS  (WIN),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .xpos                 (xpos),
    .new_game             (new_game),
    .points_first_player  (p1),
    .points_second_player (p2),
    .point_scored         (point_scored),
    .scorer               (scorer),
    .serve_hold           (serve_hold),
    .game_over            (game_over),
    .winner               (winner)
  );

  // Referee model: mode 0 idle, 1 live ball, 2 serving, 3 game finished
  int m_mode, m_s1, m_s2, m_hold_left, m_prev;
  bit m_pt, m_scorer, m_winner;

  task automatic model_step();
    bit lh, rh;
    lh = (int'(xpos) == 0) && (m_prev != 0);
    rh = (int'(xpos) >= 1024) && (m_prev < 1024);
    m_pt = 1'b0;
    if (rst) begin
      m_mode = 0; m_s1 = 0; m_s2 = 0; m_hold_left = 0;
      m_scorer = 1'b0; m_winner = 1'b0;
    end else if (new_game) begin
      m_mode = 1; m_s1 = 0; m_s2 = 0; m_hold_left = 0; m_winner = 1'b0;
    end else if (m_mode == 1) begin
      if (lh || rh) begin
        m_pt = 1'b1;
        m_scorer = lh;
        if (lh) m_s2++; else m_s1++;
        if ((lh ? m_s2 : m_s1) == WIN) begin
          m_mode = 3; m_winner = lh;
        end else begin
          m_mode = 2; m_hold_left = HOLD;
        end
      end
    end else if (m_mode == 2) begin
      m_hold_left--;
      if (m_hold_left == 0) m_mode = 1;
    end
    m_prev = int'(xpos);
  endtask

  function automatic logic [18:0] exp_vec();
    return {7'(m_s1), 7'(m_s2), m_pt, m_scorer, (m_mode == 2), (m_mode == 3), m_winner};
  endfunction

  wire [18:0] obs_vec = {p1, p2, point_scored, scorer, serve_hold, game_over, winner};

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_hold_end();
    for (int i = 0; i < 20 && serve_hold; i++) tick();
    n_assert++;
    if (serve_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_timeout: serve_hold=%b required 0", serve_hold);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; new_game = 1'b0; xpos = 11'd50;
    tick(); tick();
    n_assert++;
    if (obs_vec !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", obs_vec);
    end
    rst = 1'b0;
    xpos = 11'd0; tick();
    n_assert++;
    if (point_scored !== 1'b0 || p2 !== 7'd0) begin
      n_fail++;
      $display("FAIL idle_ignores_hit: pt=%b p2=%0d required 0/0", point_scored, p2);
    end
  endtask

  task automatic test_left_miss();
    int hold_cnt, extra;
    new_game = 1'b1; tick(); new_game = 1'b0;
    xpos = 11'(50 + $urandom_range(0, 400)); tick();
    xpos = 11'd0; tick();
    n_assert++;
    if (p2 !== 7'd1 || point_scored !== 1'b1 || scorer !== 1'b1 || serve_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL left_miss: p2=%0d pt=%b scorer=%b hold=%b required 1/1/1/1",
               p2, point_scored, scorer, serve_hold);
    end
    hold_cnt = serve_hold ? 1 : 0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (serve_hold) hold_cnt++;
      if (point_scored) extra++;
      n_assert++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL left_miss_cycle%0d: got %h required %h", i, obs_vec, exp_vec());
      end
    end
    n_assert++;
    if (hold_cnt != HOLD || extra != 0 || p2 !== 7'd1) begin
      n_fail++;
      $display("FAIL left_miss_hold: hold_cycles=%0d extra_points=%0d p2=%0d required %0d/0/1",
               hold_cnt, extra, p2, HOLD);
    end
  endtask

  task automatic test_right_miss();
    xpos = 11'd1000; tick();
    xpos = 11'd1024; tick();
    n_assert++;
    if (p1 !== 7'd1 || scorer !== 1'b0 || point_scored !== 1'b1) begin
      n_fail++;
      $display("FAIL right_miss_exact: p1=%0d scorer=%b pt=%b required 1/0/1", p1, scorer, point_scored);
    end
    wait_hold_end();
    xpos = 11'd1020; tick();
    xpos = 11'd1030; tick();
    n_assert++;
    if (p1 !== 7'd2 || scorer !== 1'b0 || point_scored !== 1'b1) begin
      n_fail++;
      $display("FAIL right_miss_over: p1=%0d scorer=%b pt=%b required 2/0/1", p1, scorer, point_scored);
    end
    wait_hold_end();
  endtask

  task automatic test_hold_masking();
    new_game = 1'b1; tick(); new_game = 1'b0;
    xpos = 11'd512; tick();
    xpos = 11'd0;   tick();
    xpos = 11'd512; tick();
    xpos = 11'd0;   tick();
    n_assert++;
    if (point_scored !== 1'b0 || p2 !== 7'd1 || serve_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_mask: pt=%b p2=%0d hold=%b required 0/1/1", point_scored, p2, serve_hold);
    end
    xpos = 11'd512;
    wait_hold_end();
    xpos = 11'd0; tick();
    n_assert++;
    if (p2 !== 7'd2 || point_scored !== 1'b1 || scorer !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_after: p2=%0d pt=%b scorer=%b required 2/1/1", p2, point_scored, scorer);
    end
    wait_hold_end();
  endtask

  task automatic test_game_over();
    new_game = 1'b1; tick(); new_game = 1'b0;
    for (int g = 0; g < WIN; g++) begin
      xpos = 11'($urandom_range(1, 1023)); tick();
      xpos = 11'($urandom_range(1024, 2047)); tick();
      if (g < WIN - 1) wait_hold_end();
    end
    n_assert++;
    if (p1 !== 7'd3 || game_over !== 1'b1 || winner !== 1'b0 || serve_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL game_over: p1=%0d over=%b winner=%b hold=%b required 3/1/0/0",
               p1, game_over, winner, serve_hold);
    end
    xpos = 11'd500;  tick();
    xpos = 11'd1024; tick();
    xpos = 11'd0;    tick();
    n_assert++;
    if (p1 !== 7'd3 || p2 !== 7'd0 || point_scored !== 1'b0 || game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL over_frozen: p1=%0d p2=%0d pt=%b over=%b required 3/0/0/1",
               p1, p2, point_scored, game_over);
    end
    new_game = 1'b1; tick(); new_game = 1'b0;
    n_assert++;
    if (p1 !== 7'd0 || p2 !== 7'd0 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL over_restart: p1=%0d p2=%0d over=%b required 0/0/0", p1, p2, game_over);
    end
  endtask

  task automatic test_collision_reset();
    xpos = 11'd300; tick();
    xpos = 11'd0; new_game = 1'b1; tick(); new_game = 1'b0;
    n_assert++;
    if (p1 !== 7'd0 || p2 !== 7'd0 || point_scored !== 1'b0) begin
      n_fail++;
      $display("FAIL collision: p1=%0d p2=%0d pt=%b required 0/0/0", p1, p2, point_scored);
    end
    xpos = 11'd300; tick();
    xpos = 11'd0;   tick();
    tick(); tick(); tick();
    n_assert++;
    if (serve_hold !== 1'b1 || p2 !== 7'd1) begin
      n_fail++;
      $display("FAIL pre_reset_hold: hold=%b p2=%0d required 1/1", serve_hold, p2);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_assert++;
    if (serve_hold !== 1'b0 || p1 !== 7'd0 || p2 !== 7'd0 || point_scored !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: hold=%b p1=%0d p2=%0d pt=%b required 0/0/0/0",
               serve_hold, p1, p2, point_scored);
    end
    xpos = 11'd500;  tick();
    xpos = 11'd0;    tick();
    xpos = 11'd1024; tick();
    n_assert++;
    if (p1 !== 7'd0 || p2 !== 7'd0 || point_scored !== 1'b0 || serve_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: p1=%0d p2=%0d pt=%b required 0/0/0", p1, p2, point_scored);
    end
    new_game = 1'b1; tick(); new_game = 1'b0;
    xpos = 11'd0; tick();
    n_assert++;
    if (p2 !== 7'd1 || point_scored !== 1'b1) begin
      n_fail++;
      $display("FAIL play_after_idle: p2=%0d pt=%b required 1/1", p2, point_scored);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      xpos = 11'd0;
      else if (r < 5) xpos = 11'($urandom_range(1024, 2047));
      else            xpos = 11'($urandom_range(1, 1023));
      new_game = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 149) == 0);
      tick();
      n_assert++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h required %h", i, obs_vec, exp_vec());
      end
    end
    rst = 1'b0; new_game = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left_miss();
    test_right_miss();
    test_hold_masking();
    test_game_over();
    test_collision_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/score_ctl.md
Name: score_ctl

Overview:
- Referee block for the Pong datapath. It watches the ball position coming out of ball_ctl and detects misses at the left or right edge.
- On a miss it credits the opposite player, freezes play for a serve delay, and declares game over at the winning score.
- It drives points_first_player and points_second_player, which ball_ctl and the score display consume, closing the ball_ctl loop from the consumer side.

Parameters:
- X_LEFT, 0: xpos value meaning the ball left the field past player 1 (left paddle).
- X_RIGHT, 1024: xpos value (and above) meaning the ball left the field past player 2.
- WIN_POINTS, 11: score that ends the game; range 1..99.
- HOLD_CYCLES, 65_000_000: serve-delay length in clk cycles (1 s at 65 MHz); minimum 2.

Ports:
- clk  in  1  pixel/system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- xpos  in  11  ball x position from ball_ctl.
- new_game  in  1  single-cycle start request (debounced button).
- points_first_player  out  7  player 1 score, 0..99.
- points_second_player  out  7  player 2 score, 0..99.
- point_scored  out  1  one-cycle pulse on each credited point.
- scorer  out  1  0 = player 1, 1 = player 2; valid with point_scored, held until the next point.
- serve_hold  out  1  high while the serve delay runs; ball_ctl keeps the ball at centre.
- game_over  out  1  high from the winning point until new_game or rst.
- winner  out  1  0 = player 1, 1 = player 2; meaningful only while game_over.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Both scores 0; all outputs 0; state IDLE; hold counter 0; xpos_prev loaded with the current xpos.
  - Reset mid-hold or mid-game aborts immediately; there is no pending pulse after reset.
- Edge detection:
  - xpos_prev is registered every cycle.
  - left_hit = (xpos == X_LEFT) && (xpos_prev != X_LEFT).
  - right_hit = (xpos >= X_RIGHT) && (xpos_prev < X_RIGHT).
  - Hits are edge-triggered only. A ball parked at an edge never re-scores; it must leave and return.
  - Both hits in the same cycle cannot occur and is not required to be handled.
- States:
  - IDLE: scores frozen, hits ignored. new_game goes to PLAY.
  - PLAY, on a hit:
    - left_hit credits player 2; right_hit credits player 1.
    - The credited score increments in the cycle after the hit; point_scored pulses that same cycle.
    - If the new score equals WIN_POINTS: go to OVER, with game_over=1 and winner=scorer, in that same cycle.
    - Otherwise go to HOLD: serve_hold=1 and the counter is cleared.
  - HOLD:
    - The counter increments each cycle; hits are ignored.
    - When the counter reaches HOLD_CYCLES-1: serve_hold=0 next cycle and return to PLAY. Total hold is HOLD_CYCLES cycles.
  - OVER: scores, winner and game_over are held; hits are ignored. new_game goes to PLAY.
- new_game:
  - In any state, new_game clears both scores, game_over, serve_hold and the counter next cycle, then enters PLAY.
  - new_game in the same cycle as a hit: new_game wins and the point is discarded.
- Arithmetic:
  - Scores saturate at 99, which is reachable only if WIN_POINTS > 99; the parameter check forbids that.
  - The counter width is $clog2(HOLD_CYCLES).
- Latency: hit to point_scored/score update is 1 cycle; hit to serve_hold is 1 cycle.

Decomposition:
- Package pong_pkg holds:
  - X_LEFT, X_RIGHT, WIN_POINTS, HOLD_CYCLES defaults.
  - SCREEN_W=1024.
  - The typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} score_state_t.
  - The typedef enum logic {PLAYER_1, PLAYER_2} player_t.
- One sub-module, hold_timer: a parameterised down/up counter with start and done pulse, reused later for the post-game banner.

Test Plan:
- Use HOLD_CYCLES=8 and WIN_POINTS=3 for all scenarios.
- Left miss:
  - Stimulus: rst, new_game, xpos 50→0 held.
  - Required response: one point_scored with scorer=1; points_second_player=1 one cycle after xpos=0; serve_hold high exactly 8 cycles; no second point while xpos stays at 0.
- Right miss:
  - Stimulus: xpos 1000→1024.
  - Required response: points_first_player=1, scorer=0.
  - Stimulus: xpos 1020→1030.
  - Required response: also credits player 1 (the ≥ compare is used).
- Hold masking:
  - Stimulus: during HOLD, xpos 0→512→0.
  - Required response: no point. After serve_hold falls, 512→0 credits player 2.
- Game over:
  - Stimulus: three right misses.
  - Required response: points_first_player=3, game_over=1, winner=0, serve_hold=0. A further miss changes nothing.
  - Stimulus: new_game.
  - Required response: scores 0, game_over=0 next cycle.
- Collision and reset:
  - Stimulus: new_game in the same cycle as a left hit.
  - Required response: scores 0, no point_scored.
  - Stimulus: rst asserted at hold cycle 4.
  - Required response: serve_hold=0 and scores 0 next cycle; IDLE ignores hits until new_game.
